keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Sequencer for the 4x4 matrix keypad in front of the two-digit display register.
- Drives one column low at a time and samples synchronised rows.
- Debounces a detected key, then presents a stable key code with a level `press` that stays high while the key is held.
- Locks out all other keys until the held key is released and the release is debounced; downstream logic edge-detects `press`.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven before its rows are evaluated; must be ≥ 3 to cover synchroniser latency.
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles required to accept a press or a release; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rows_n  in  4  raw keypad rows, active-low, externally pulled up, asynchronous.
- cols_n  out  4  column drive, one-cold; bit i low = column i active.
- press  out  1  high while a debounced key is held.
- key  out  4  hex code of the accepted key; stable whenever press=1.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=SCAN, col_idx=0, cols_n=4'b1110, press=0, key=0.
  - All counters are 0 and synchroniser flops are 1.
- Synchronisation: rows_n passes through a 2-flop synchroniser (rows_s). All decisions use rows_s only, so latency is 2 cycles.
- Key map (row,col → key):
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D
- SCAN:
  - Drive column col_idx; dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle with rows_s≠4'b1111: latch col_idx and the lowest-index low row, clear the debounce counter, go to DEBOUNCE.
  - Otherwise at dwell end: col_idx wraps 3→0, dwell counter clears.
  - Before dwell end, rows are ignored (settling).
- DEBOUNCE:
  - Hold the latched column.
  - Latched row low: counter increments. When the counter reaches DEBOUNCE_CYCLES, go to HELD; on the same edge press←1 and key←map(row,col).
  - Latched row high on any cycle: return to SCAN at the next column (wrap), press stays 0, key unchanged.
- HELD:
  - Hold the latched column; press=1.
  - Latched row goes high: go to RELEASE with the counter cleared.
  - Other row activity is ignored (lockout), including a second key in the same column.
- RELEASE:
  - Latched row low again: go back to HELD, counter cleared, press stays 1.
  - Latched row high for DEBOUNCE_CYCLES consecutive cycles: press←0, go to SCAN at the next column.
  - key retains its last value after release.
- Latency: press rises exactly DEBOUNCE_CYCLES cycles after entering DEBOUNCE when the row stays low; it falls exactly DEBOUNCE_CYCLES cycles after entering RELEASE.
- Reset mid-operation: immediate return to the reset state from any state. press drops in that cycle; there is no partial key output.
- Counter widths: $clog2(max(SCAN_DIV, DEBOUNCE_CYCLES)+1). No counter may wrap; each saturates at its terminal compare.
- Simultaneous keys in different columns: the first column scanned wins; the others are never seen until release.

Decomposition:
- Package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=4.
  - State enum: SCAN, DEBOUNCE, HELD, RELEASE.
  - KEY_MAP constant array [row][col] of 4-bit codes.
- Sub-module sync2: parameterised-width 2-flop synchroniser, reset value 1.
- keypad_scanner holds the FSM, dwell/debounce counters and output registers.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset release with no keys: cols_n cycles 1110→1101→1011→0111→1110, each held 4 cycles; press stays 0.
- Hold row1/col2 steady: press rises 8 cycles after DEBOUNCE entry with key=4'h6. cols_n stays 1011 while held. Release: press falls 8 cycles after RELEASE entry and key stays 6.
- Bounce on press: row1/col0 low for 3 cycles, then high, then low. No press on the first attempt; scan resumes at col1; the next stable hold gives key=4'h4.
- Bounce on release: while HELD, row high for 4 cycles then low → press never drops. A later 8-cycle high drops press.
- Lockout: hold key 5 until press=1, then add key 9 → key stays 5. Release 5 while 9 is still held → after release debounce, scan finds 9 and press re-rises with key=4'h9.
- Reset asserted in HELD → next edge: press=0, key=0, cols_n=1110, state SCAN.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  // Indexed [row][col]; row 0 is the top row of the keypad.
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      if (!rows[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones (idle rows).
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and single-key lockout.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic                press,
  output logic [3:0]          key
);

  localparam int unsigned MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_ROWS-1:0] rows_s;
  state_e              state_q;
  logic [1:0]          col_q;
  logic [1:0]          row_q;
  logic [CW-1:0]       dwell_q;
  logic [CW-1:0]       deb_q;
  logic [NUM_COLS-1:0] cols_n_q;
  logic                press_q;
  logic [3:0]          key_q;
  logic [1:0]          col_nxt_d;
  logic                row_lvl;

  sync2 #(.WIDTH(NUM_ROWS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rows_n),
    .q_o   (rows_s)
  );

  always_comb begin
    col_nxt_d = col_q + 2'd1;
    row_lvl   = rows_s[row_q];
  end

  // Counters compare before incrementing so neither can run past its terminal value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SCAN;
      col_q    <= '0;
      row_q    <= '0;
      dwell_q  <= '0;
      deb_q    <= '0;
      cols_n_q <= 4'b1110;
      press_q  <= 1'b0;
      key_q    <= '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (rows_s != '1) begin
              row_q   <= lowest_low(rows_s);
              deb_q   <= '0;
              state_q <= DEBOUNCE;
            end else begin
              col_q    <= col_nxt_d;
              cols_n_q <= col_drive(col_nxt_d);
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (!row_lvl) begin
            deb_q <= deb_q + 1'b1;
            if (deb_q == DEB_LAST) begin
              state_q <= HELD;
              press_q <= 1'b1;
              key_q   <= KEY_MAP[row_q][col_q];
            end
          end else begin
            state_q  <= SCAN;
            dwell_q  <= '0;
            col_q    <= col_nxt_d;
            cols_n_q <= col_drive(col_nxt_d);
          end
        end

        HELD: begin
          if (row_lvl) begin
            state_q <= RELEASE;
            deb_q   <= '0;
          end
        end

        RELEASE: begin
          if (!row_lvl) begin
            state_q <= HELD;
            deb_q   <= '0;
          end else begin
            deb_q <= deb_q + 1'b1;
            if (deb_q == DEB_LAST) begin
              state_q  <= SCAN;
              press_q  <= 1'b0;
              dwell_q  <= '0;
              col_q    <= col_nxt_d;
              cols_n_q <= col_drive(col_nxt_d);
            end
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign cols_n = cols_n_q;
  assign press  = press_q;
  assign key    = key_q;

endmodule
